// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: pipeline request/response and data-memory word port of the MEM-stage load/store unit.
interface mem_access_unit_if;
   logic        req;
   logic        wr;
   logic [2:0]  op;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        stall;
   logic [31:0] rdata;
   logic        rvalid;
   logic        exc;
   logic [9:0]  dm_addr;
   logic [31:0] dm_din;
   logic        dm_wr;
   logic [31:0] dm_dout;
   modport slave (
      input  req, wr, op, addr, wdata, dm_dout,
      output stall, rdata, rvalid, exc, dm_addr, dm_din, dm_wr
   );
   modport master (
      output req, wr, op, addr, wdata, dm_dout,
      input  stall, rdata, rvalid, exc, dm_addr, dm_din, dm_wr
   );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/half/word loads and stores over a word-only memory port; sub-word stores use read-modify-write.
// Optional MEM_MISALIGN_EXC_EN turns misaligned half/word accesses into an exc pulse instead of aligning them down.
module mem_access_unit (
   input logic clk,
   input logic rst,
   mem_access_unit_if.slave bus
);
   typedef enum logic {IDLE, RMW} state_t;
   state_t state, state_nx;
   logic is_byte, is_half, is_word, valid_op, go, mis, idle_go, sub_st;
   logic [7:0] lb_v;
   logic [15:0] lh_v;
   logic [31:0] ld_v, merged;
   logic [31:0] lat_word;
   logic [9:0] lat_addr;
   logic [1:0] lat_lane;
   logic lat_byte;
   logic [15:0] lat_wdata;
   logic unused;
   assign unused = &{1'b0, bus.addr[31:12]};
   assign is_byte = bus.op[1:0] == 2'b00;
   assign is_half = bus.op[1:0] == 2'b01;
   assign is_word = bus.op == 3'b011;
   assign valid_op = is_word || !bus.op[1];
   assign go = bus.req && valid_op;
`ifdef MEM_MISALIGN_EXC_EN
   assign mis = (is_half && bus.addr[0]) || (is_word && bus.addr[1:0] != 2'b00);
`else
   assign mis = 1'b0;
`endif
   assign idle_go = state == IDLE && go && !mis;
   assign sub_st = idle_go && bus.wr && !is_word;
   assign lb_v = bus.dm_dout[{bus.addr[1:0], 3'b000} +: 8];
   assign lh_v = bus.dm_dout[{bus.addr[1], 4'b0000} +: 16];
   assign ld_v = is_word ? bus.dm_dout :
                 is_byte ? {{24{!bus.op[2] && lb_v[7]}}, lb_v} :
                           {{16{!bus.op[2] && lh_v[15]}}, lh_v};
   always_comb begin
      merged = lat_word;
      if (lat_byte) merged[{lat_lane, 3'b000} +: 8] = lat_wdata[7:0];
      else merged[{lat_lane[1], 4'b0000} +: 16] = lat_wdata;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nx;
   always_comb
      state_nx = state == RMW ? IDLE : sub_st ? RMW : IDLE;
   // The held upstream request during RMW is deliberately ignored.
   always_comb begin
      bus.stall = !rst && sub_st;
      bus.dm_wr = !rst && (state == RMW || (idle_go && bus.wr && is_word));
      bus.dm_addr = state == RMW ? lat_addr : bus.addr[11:2];
      bus.dm_din = state == RMW ? merged : bus.wdata;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         bus.rdata <= '0;
         bus.rvalid <= 1'b0;
         bus.exc <= 1'b0;
         lat_word <= '0;
         lat_addr <= '0;
         lat_lane <= '0;
         lat_byte <= 1'b0;
         lat_wdata <= '0;
      end else begin
         bus.rvalid <= idle_go && !bus.wr;
         bus.exc <= state == IDLE && go && mis;
         if (idle_go && !bus.wr) bus.rdata <= ld_v;
         if (sub_st) begin
            lat_word <= bus.dm_dout;
            lat_addr <= bus.addr[11:2];
            lat_lane <= bus.addr[1:0];
            lat_byte <= is_byte;
            lat_wdata <= bus.wdata[15:0];
         end
      end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench; expected load results are queued at issue and popped on rvalid.
module tb_mem_access_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic init = 1'b0;
   int errors = 0;
   int checks = 0;
   logic [31:0] q[$];
   logic [31:0] mem [0:1023];
   mem_access_unit_if bus ();
   mem_access_unit dut (.clk(clk), .rst(rst), .bus(bus.slave));
   always #5 clk = ~clk;
   assign bus.dm_dout = mem[bus.dm_addr];
   always @(posedge clk)
      if (init) mem[4] <= 32'h8899AABB;
      else if (bus.dm_wr) mem[bus.dm_addr] <= bus.dm_din;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic drive(input logic w, input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.req = 1'b1;
      bus.wr = w;
      bus.op = o;
      bus.addr = a;
      bus.wdata = d;
      #1;
   endtask
   task automatic idle();
      @(negedge clk);
      bus.req = 1'b0;
      #1;
   endtask
   task automatic load(input logic [2:0] o, input logic [31:0] a, input logic [31:0] exp);
      drive(1'b0, o, a, 32'h0);
      check("ld_stall", bus.stall, 0);
      q.push_back(exp);
   endtask
   task automatic sub_store(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp);
      drive(1'b1, o, a, d);
      check("rmw_stall", bus.stall, 1);
      check("rmw_nowr", bus.dm_wr, 0);
      @(negedge clk);
      #1;
      check("rmw_stall_off", bus.stall, 0);
      check("rmw_wr", bus.dm_wr, 1);
      check("rmw_addr", bus.dm_addr, a[11:2]);
      check("rmw_din", bus.dm_din, exp);
   endtask
   always @(negedge clk)
      if (!rst && bus.rvalid) begin
         if (q.size() == 0) check("rvalid_spurious", bus.rvalid, 0);
         else check("rdata", bus.rdata, q.pop_front());
      end
   initial begin
      #100000;
      $display("FAIL timeout: got 1 expected 0");
      $fatal(1);
   end
   initial begin
      bus.req = 1'b1;
      bus.wr = 1'b1;
      bus.op = 3'b011;
      bus.addr = 32'h10;
      bus.wdata = 32'h0;
      #1;
      check("rst_dm_wr", bus.dm_wr, 0);
      check("rst_stall_sw", bus.stall, 0);
      @(negedge clk);
      bus.op = 3'b000;
      #1;
      check("rst_stall_sb", bus.stall, 0);
      check("rst_rdata", bus.rdata, 0);
      check("rst_rvalid", bus.rvalid, 0);
      check("rst_exc", bus.exc, 0);
      bus.req = 1'b0;
      init = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      init = 1'b0;
      load(3'b011, 32'h10, 32'h8899AABB);
      load(3'b000, 32'h13, 32'hFFFFFF88);
      load(3'b100, 32'h13, 32'h00000088);
      load(3'b001, 32'h12, 32'hFFFF8899);
      load(3'b101, 32'h10, 32'h0000AABB);
      load(3'b000, 32'h10, 32'hFFFFFFBB);
      idle();
      sub_store(3'b000, 32'h11, 32'h12345677, 32'h889977BB);
      load(3'b011, 32'h10, 32'h889977BB);
      sub_store(3'b001, 32'h12, 32'h0000CAFE, 32'hCAFE77BB);
      load(3'b011, 32'h10, 32'hCAFE77BB);
      sub_store(3'b000, 32'h10, 32'h00000011, 32'hCAFE7711);
      sub_store(3'b001, 32'h12, 32'h0000BEEF, 32'hBEEF7711);
      load(3'b011, 32'h10, 32'hBEEF7711);
      drive(1'b1, 3'b011, 32'h14, 32'hDEADBEEF);
      check("sw_stall", bus.stall, 0);
      check("sw_wr", bus.dm_wr, 1);
      check("sw_din", bus.dm_din, 32'hDEADBEEF);
      load(3'b011, 32'h14, 32'hDEADBEEF);
      load(3'b000, 32'h16, 32'hFFFFFFAD);
      drive(1'b0, 3'b010, 32'h10, 32'h0);
      check("undef_ld_wr", bus.dm_wr, 0);
      drive(1'b1, 3'b110, 32'h10, 32'h0);
      check("undef_st_wr", bus.dm_wr, 0);
      check("undef_st_stall", bus.stall, 0);
      drive(1'b1, 3'b011, 32'h10, 32'h0);
      bus.req = 1'b0;
      #1;
      check("noreq_wr", bus.dm_wr, 0);
      idle();
      check("undef_mem", mem[4], 32'hBEEF7711);
`ifdef MEM_MISALIGN_EXC_EN
      drive(1'b0, 3'b011, 32'h11, 32'h0);
      check("mis_stall", bus.stall, 0);
      idle();
      check("mis_exc", bus.exc, 1);
      check("mis_rvalid", bus.rvalid, 0);
      drive(1'b1, 3'b001, 32'h13, 32'h0000AAAA);
      check("mis_st_stall", bus.stall, 0);
      check("mis_st_wr", bus.dm_wr, 0);
      idle();
      check("mis_st_exc", bus.exc, 1);
      idle();
      check("exc_pulse", bus.exc, 0);
      check("mis_mem", mem[4], 32'hBEEF7711);
`else
      load(3'b011, 32'h11, 32'hBEEF7711);
      load(3'b001, 32'h13, 32'hFFFFBEEF);
      idle();
      check("no_exc", bus.exc, 0);
      idle();
      check("no_exc2", bus.exc, 0);
`endif
      idle();
      drive(1'b1, 3'b000, 32'h10, 32'h000000EE);
      check("rst_rmw_stall", bus.stall, 1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_rmw_wr", bus.dm_wr, 0);
      check("rst_rmw_stall0", bus.stall, 0);
      check("rst_rmw_rdata", bus.rdata, 0);
      check("rst_rmw_rvalid", bus.rvalid, 0);
      idle();
      check("rst_rmw_mem", mem[4], 32'hBEEF7711);
      rst = 1'b0;
      load(3'b011, 32'h10, 32'hBEEF7711);
      repeat (3) idle();
      check("q_empty", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
